// File: rtl/segre_mem_arbiter.sv
// Main-memory line-port arbiter shared by the icache fill path and the dcache fill/writeback path.
// Optional build macro SEGRE_MEM_ARB_ROUND_ROBIN_EN: alternate grants on simultaneous requests.
module segre_mem_arbiter #(
    parameter int unsigned ADDR_SIZE             = 32,
    parameter int unsigned CACHE_LINE_SIZE_BYTES = 16,
    parameter int unsigned MEM_LATENCY           = 5
) (
    input  logic                               clk_i,
    input  logic                               rsn_i,
    input  logic                               ic_rd_i,
    input  logic [ADDR_SIZE-1:0]               ic_addr_i,
    output logic [CACHE_LINE_SIZE_BYTES*8-1:0] ic_line_o,
    output logic                               ic_ready_o,
    input  logic                               dc_rd_i,
    input  logic                               dc_wr_i,
    input  logic [ADDR_SIZE-1:0]               dc_addr_i,
    input  logic [ADDR_SIZE-1:0]               dc_wb_addr_i,
    input  logic [CACHE_LINE_SIZE_BYTES*8-1:0] dc_line_i,
    output logic [CACHE_LINE_SIZE_BYTES*8-1:0] dc_line_o,
    output logic                               dc_ready_o,
    output logic                               mem_rd_o,
    output logic                               mem_wr_o,
    output logic [ADDR_SIZE-1:0]               mem_addr_o,
    output logic [CACHE_LINE_SIZE_BYTES*8-1:0] mem_wr_line_o,
    input  logic [CACHE_LINE_SIZE_BYTES*8-1:0] mem_rd_line_i
);

    localparam int unsigned LINE_W = CACHE_LINE_SIZE_BYTES * 8;
    localparam logic [ADDR_SIZE-1:0] ALIGN_MASK = ~(ADDR_SIZE'(CACHE_LINE_SIZE_BYTES - 1));
    localparam logic [3:0] LAT_LAST = 4'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WB,
        RD,
        RESP
    } state_t;

    typedef enum logic {
        OWN_IC,
        OWN_DC
    } owner_t;

    state_t                state_q;
    state_t                state_d;
    owner_t                owner_q;
    logic [ADDR_SIZE-1:0]  fill_addr_q;
    logic [ADDR_SIZE-1:0]  wb_addr_q;
    logic [LINE_W-1:0]     victim_q;
    logic [LINE_W-1:0]     line_q;
    logic [3:0]            cnt_q;
    logic                  need_rd_q;

    logic dc_req;
    logic grant_dc;
    logic grant_ic;
    logic lat_done;

    assign dc_req   = dc_rd_i | dc_wr_i;
    assign lat_done = (cnt_q == LAT_LAST);

`ifdef SEGRE_MEM_ARB_ROUND_ROBIN_EN
    owner_t last_owner_q;

    // On a tie, the dcache wins only if the icache was granted last.
    assign grant_dc = dc_req & (~ic_rd_i | (last_owner_q == OWN_IC));
`else
    assign grant_dc = dc_req;
`endif
    assign grant_ic = ic_rd_i & ~grant_dc;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_dc) begin
                    state_d = dc_wr_i ? WB : RD;
                end else if (grant_ic) begin
                    state_d = RD;
                end
            end
            WB: begin
                if (lat_done) begin
                    state_d = need_rd_q ? RD : RESP;
                end
            end
            RD: begin
                if (lat_done) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode the registered state only, so reset clears them asynchronously.
    always_comb begin
        ic_ready_o    = 1'b0;
        ic_line_o     = '0;
        dc_ready_o    = 1'b0;
        dc_line_o     = '0;
        mem_rd_o      = 1'b0;
        mem_wr_o      = 1'b0;
        mem_addr_o    = '0;
        mem_wr_line_o = '0;
        case (state_q)
            WB: begin
                mem_wr_o      = 1'b1;
                mem_addr_o    = wb_addr_q & ALIGN_MASK;
                mem_wr_line_o = victim_q;
            end
            RD: begin
                mem_rd_o   = 1'b1;
                mem_addr_o = fill_addr_q & ALIGN_MASK;
            end
            RESP: begin
                if (owner_q == OWN_DC) begin
                    dc_ready_o = 1'b1;
                    dc_line_o  = line_q;
                end else begin
                    ic_ready_o = 1'b1;
                    ic_line_o  = line_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rsn_i) begin
        if (rsn_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if ((state_d == state_q) && ((state_q == WB) || (state_q == RD))) begin
                cnt_q <= cnt_q + 4'd1;
            end else begin
                cnt_q <= '0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rsn_i) begin
        if (rsn_i) begin
            owner_q     <= OWN_IC;
            fill_addr_q <= '0;
            wb_addr_q   <= '0;
            victim_q    <= '0;
            need_rd_q   <= 1'b0;
            line_q      <= '0;
        end else begin
            if ((state_q == IDLE) && (grant_dc || grant_ic)) begin
                owner_q     <= grant_dc ? OWN_DC : OWN_IC;
                fill_addr_q <= grant_dc ? dc_addr_i : ic_addr_i;
                wb_addr_q   <= dc_wb_addr_i;
                victim_q    <= dc_line_i;
                need_rd_q   <= grant_dc ? dc_rd_i : 1'b1;
                line_q      <= '0;
            end else if ((state_q == RD) && lat_done) begin
                line_q <= mem_rd_line_i;
            end
        end
    end

`ifdef SEGRE_MEM_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk_i or posedge rsn_i) begin
        if (rsn_i) begin
            last_owner_q <= OWN_DC;
        end else if ((state_q == IDLE) && (grant_dc || grant_ic)) begin
            last_owner_q <= grant_dc ? OWN_DC : OWN_IC;
        end
    end
`endif

endmodule

// File: doc/segre_mem_arbiter.md
Name: segre_mem_arbiter

Overview:
- Shares the single main-memory line port between the instruction-cache miss path and the data-cache miss/writeback path.
- Sits between the IF/MEM stage caches and main memory. Main memory is fixed-latency and has no acknowledge.
- Sequences each transaction: grant, optional dirty-line writeback, line fill, then a one-cycle ready pulse back to the owning cache.

Parameters:
- ADDR_SIZE, 32, address width in bits.
- CACHE_LINE_SIZE_BYTES, 16, line size in bytes; must be a power of 2.
- MEM_LATENCY, 5, cycles memory needs per read or write; legal range 1..15.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rsn_i  in  1  reset; asynchronous, active-high (1 = reset).
- ic_rd_i  in  1  icache line-fill request; level, held until ic_ready_o.
- ic_addr_i  in  ADDR_SIZE  icache miss address.
- ic_line_o  out  CACHE_LINE_SIZE_BYTES*8  fill line to icache.
- ic_ready_o  out  1  one-cycle pulse: ic_line_o valid, transaction done.
- dc_rd_i  in  1  dcache line-fill request; level, held until dc_ready_o.
- dc_wr_i  in  1  dcache dirty writeback request; level, held until dc_ready_o.
- dc_addr_i  in  ADDR_SIZE  dcache fill address.
- dc_wb_addr_i  in  ADDR_SIZE  dcache victim address.
- dc_line_i  in  CACHE_LINE_SIZE_BYTES*8  victim line.
- dc_line_o  out  CACHE_LINE_SIZE_BYTES*8  fill line to dcache.
- dc_ready_o  out  1  one-cycle pulse: dcache transaction done.
- mem_rd_o  out  1  memory read strobe.
- mem_wr_o  out  1  memory write strobe.
- mem_addr_o  out  ADDR_SIZE  line-aligned memory address.
- mem_wr_line_o  out  CACHE_LINE_SIZE_BYTES*8  write data.
- mem_rd_line_i  in  CACHE_LINE_SIZE_BYTES*8  read data; valid on the last cycle of a read.

Behaviour:
- FSM states: IDLE, WB, RD, RESP.
- Registered state: owner (IC/DC), latched fill address, latched writeback address, latched victim line, 4-bit latency counter, response line buffer.
- Reset values: state=IDLE, counter=0, owner=IC, line buffer=0. All outputs 0.
- Reset mid-transaction: the transaction is aborted immediately, no ready pulse is produced, and memory strobes drop asynchronously.
- IDLE:
  - Samples the requests; grant priority is dcache over icache (fixed).
  - On grant, latches owner, addresses and dc_line_i.
  - DC with dc_wr_i=1 goes to WB; DC with only dc_rd_i goes to RD; IC goes to RD; no request stays in IDLE.
  - Grant decision and latching take 1 cycle; strobes start in the next state.
- WB:
  - mem_wr_o=1, mem_addr_o = latched wb address with low log2(CACHE_LINE_SIZE_BYTES) bits zeroed, mem_wr_line_o = latched victim line.
  - Lasts exactly MEM_LATENCY cycles (counter 0..MEM_LATENCY-1).
  - Then goes to RD if the latched dc_rd_i was 1, else to RESP.
- RD:
  - mem_rd_o=1, mem_addr_o = latched fill address, line-aligned.
  - Lasts exactly MEM_LATENCY cycles; mem_rd_line_i is captured into the buffer on the last cycle.
  - Then goes to RESP.
- RESP:
  - One cycle. The owner's ready output is 1 and its line output carries the buffer.
  - The non-owner's ready stays 0; its line output is don't-care, driven 0.
  - Next state is IDLE.
- Request rules:
  - The requester must deassert in the cycle after its ready pulse.
  - Requests are not sampled in RESP, so a held request cannot be double-granted.
  - A request raised while another owner is active waits; it is never dropped.
  - Requester address and line inputs may change after grant without effect.
- Pure writeback (dc_wr_i only): dc_ready_o pulses after WB; dc_line_o = 0.
- Counter resets to 0 on every state entry. Counter overflow is impossible within the legal MEM_LATENCY range.
- Simultaneous ic_rd_i and dc_rd_i in IDLE: DC is granted; IC is granted in the IDLE cycle after the DC RESP.
- mem_rd_o and mem_wr_o are never both 1.

Optional Feature:
- Macro: SEGRE_MEM_ARB_ROUND_ROBIN_EN.
- Defined: a 1-bit last-owner register (reset = DC) is added. On a simultaneous request, the requester that was not last granted wins. A single request is granted regardless.
- Undefined: fixed dcache-over-icache priority as described in Behaviour; no last-owner register.

Test Plan:
- Reset, then ic_rd_i=1, ic_addr_i=0x0000_1234, MEM_LATENCY=5 -> mem_rd_o high for 5 cycles with mem_addr_o=0x0000_1230; ic_ready_o pulses 7 cycles after the request with ic_line_o equal to the line presented on the last read cycle.
- dc_wr_i=1, dc_rd_i=1, dc_wb_addr_i=0x80, dc_addr_i=0x40 -> 5 cycles mem_wr_o at 0x80 with the victim line, then 5 cycles mem_rd_o at 0x40; a single dc_ready_o pulse after 12 cycles; mem_rd_o and mem_wr_o never overlap.
- ic_rd_i and dc_rd_i raised in the same cycle -> default build: DC served first, IC ready after 14 cycles. ROUND_ROBIN build with last owner = DC: IC served first.
- dc_wr_i only -> dc_ready_o after 7 cycles; no mem_rd_o ever asserted.
- rsn_i asserted on the 3rd RD cycle -> all outputs 0 in the same cycle; no ready pulse; a fresh ic_rd_i after reset release completes normally.
- Requester holds its request through RESP and drops it the next cycle -> exactly one grant and one ready pulse per transaction.
